// File: rtl/voice_alloc.sv
// -----------------------------------------------------------------------------
// voice_alloc -- polyphonic voice allocator
//
// Takes one key event at a time (note-on / note-off) and assigns it to one of
// C_VOICES voices. A note-on retriggers a voice already playing that note,
// otherwise takes the lowest free voice, otherwise steals the oldest sounding
// voice. A note-off releases the voice playing that note, if any.
//
// Each event walks IDLE -> SCAN -> COMMIT -> DONE. evAck pulses in COMMIT.
// All voice outputs update on the edge that ends COMMIT.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-high
//   evValid     in   key event present, held until evAck
//   evOn        in   1 = note-on, 0 = note-off
//   evNote      in   note number
//   evAck       out  one-cycle event-consumed pulse
//   voiceGate   out  per-voice sounding flag
//   voiceNote   out  per-voice note, voice v at [v*C_NOTE_WIDTH +: C_NOTE_WIDTH]
//   voiceStart  out  one-cycle (re)trigger pulse per voice
//   steal       out  one-cycle pulse when a note-on evicted a sounding voice
//   activeCnt   out  number of sounding voices
// -----------------------------------------------------------------------------
module voice_alloc #(
  parameter int C_VOICES     = 4,
  parameter int C_NOTE_WIDTH = 7,
  parameter int C_AGE_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             evValid,
  input  logic                             evOn,
  input  logic [C_NOTE_WIDTH-1:0]          evNote,
  output logic                             evAck,
  output logic [C_VOICES-1:0]              voiceGate,
  output logic [C_VOICES*C_NOTE_WIDTH-1:0] voiceNote,
  output logic [C_VOICES-1:0]              voiceStart,
  output logic                             steal,
  output logic [3:0]                       activeCnt
);

  localparam int IDX_W = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                                state_q, state_d;

  // Latched event: the inputs may change once IDLE has accepted the event.
  logic                                      on_q, on_d;
  logic [C_NOTE_WIDTH-1:0]                   note_lat_q, note_lat_d;

  // Scan results captured in SCAN and consumed in COMMIT.
  logic                                      match_found_q, match_found_d;
  logic [IDX_W-1:0]                          match_idx_q, match_idx_d;
  logic                                      free_found_q, free_found_d;
  logic [IDX_W-1:0]                          free_idx_q, free_idx_d;
  logic [IDX_W-1:0]                          old_idx_q, old_idx_d;

  // Voice state.
  logic [C_VOICES-1:0]                       gate_q, gate_d;
  logic [C_VOICES-1:0][C_NOTE_WIDTH-1:0]     notes_q, notes_d;
  logic [C_VOICES-1:0][C_AGE_WIDTH-1:0]      age_q, age_d;
  logic [C_VOICES-1:0]                       start_q, start_d;
  logic                                      steal_q, steal_d;
  logic [3:0]                                cnt_q, cnt_d;

  // Combinational scan of the current voice state.
  logic                                      scan_match_found;
  logic [IDX_W-1:0]                          scan_match_idx;
  logic                                      scan_free_found;
  logic [IDX_W-1:0]                          scan_free_idx;
  logic                                      scan_old_found;
  logic [IDX_W-1:0]                          scan_old_idx;
  logic [C_AGE_WIDTH-1:0]                    scan_old_age;

  // Target voice chosen for a note-on in COMMIT.
  logic [IDX_W-1:0]                          tgt_idx;

  // ---------------------------------------------------------------------------
  // Scan: lowest-index match, lowest-index free voice, oldest sounding voice.
  // Walking upward and only replacing on a strictly greater age makes ties
  // resolve to the lowest index.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    scan_match_found = 1'b0;
    scan_match_idx   = '0;
    scan_free_found  = 1'b0;
    scan_free_idx    = '0;
    scan_old_found   = 1'b0;
    scan_old_idx     = '0;
    scan_old_age     = '0;
    for (int v = 0; v < C_VOICES; v++) begin
      if (gate_q[v] && (notes_q[v] == note_lat_q) && !scan_match_found) begin
        scan_match_found = 1'b1;
        scan_match_idx   = IDX_W'(v);
      end
      if (!gate_q[v] && !scan_free_found) begin
        scan_free_found = 1'b1;
        scan_free_idx   = IDX_W'(v);
      end
      if (gate_q[v] && (!scan_old_found || (age_q[v] > scan_old_age))) begin
        scan_old_found = 1'b1;
        scan_old_idx   = IDX_W'(v);
        scan_old_age   = age_q[v];
      end
    end
  end

  // Note-on target: retrigger a match, else take a free voice, else steal.
  always_comb begin
    if (match_found_q) begin
      tgt_idx = match_idx_q;
    end else if (free_found_q) begin
      tgt_idx = free_idx_q;
    end else begin
      tgt_idx = old_idx_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    on_d          = on_q;
    note_lat_d    = note_lat_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    gate_d        = gate_q;
    notes_d       = notes_q;
    age_d         = age_q;
    // Pulses fall back to zero unless COMMIT raises them.
    start_d       = '0;
    steal_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (evValid) begin
          on_d       = evOn;
          note_lat_d = evNote;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        match_found_d = scan_match_found;
        match_idx_d   = scan_match_idx;
        free_found_d  = scan_free_found;
        free_idx_d    = scan_free_idx;
        old_idx_d     = scan_old_idx;
        state_d       = COMMIT;
      end

      COMMIT: begin
        if (on_q) begin
          // Every other sounding voice gets one step older (saturating).
          for (int v = 0; v < C_VOICES; v++) begin
            if (IDX_W'(v) == tgt_idx) begin
              age_d[v] = '0;
            end else if (gate_q[v] && (age_q[v] != {C_AGE_WIDTH{1'b1}})) begin
              age_d[v] = age_q[v] + 1'b1;
            end
          end
          gate_d[tgt_idx]  = 1'b1;
          notes_d[tgt_idx] = note_lat_q;
          start_d[tgt_idx] = 1'b1;
          steal_d          = !match_found_q && !free_found_q;
        end else if (match_found_q) begin
          // Release keeps the note so a downstream envelope can finish it.
          gate_d[match_idx_q] = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        // Wait for the producer to drop evValid so a held request is
        // consumed only once.
        if (!evValid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Population count of the next gate vector, registered alongside it.
  always_comb begin
    cnt_d = '0;
    for (int v = 0; v < C_VOICES; v++) begin
      cnt_d = cnt_d + 4'(gate_d[v]);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the voice arrays are small flop banks, not RAM, so they take the
      // reset like any other register; a cleared note table is part of the
      // visible reset state.
      state_q       <= IDLE;
      on_q          <= 1'b0;
      note_lat_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      gate_q        <= '0;
      notes_q       <= '0;
      age_q         <= '0;
      start_q       <= '0;
      steal_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge value, independent of statement order.
      state_q       <= state_d;
      on_q          <= on_d;
      note_lat_q    <= note_lat_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_idx_q     <= old_idx_d;
      gate_q        <= gate_d;
      notes_q       <= notes_d;
      age_q         <= age_d;
      start_q       <= start_d;
      steal_q       <= steal_d;
      cnt_q         <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Masked by rst so a reset landing in COMMIT never shows an acknowledge.
  assign evAck      = (state_q == COMMIT) && !rst;
  assign voiceGate  = gate_q;
  assign voiceNote  = notes_q;
  assign voiceStart = start_q;
  assign steal      = steal_q;
  assign activeCnt  = cnt_q;

endmodule

// File: tb/tb_voice_alloc.sv
// -----------------------------------------------------------------------------
// tb_voice_alloc -- self-checking bench for voice_alloc
//
// A behavioural voice model predicts each event's outcome; the prediction is
// queued when the event is driven and popped when the DUT shows its result.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_voice_alloc;

  localparam int NV = 4;
  localparam int NW = 7;
  localparam int AW = 2;  // small age counter so saturation is reachable
  localparam int AGE_MAX = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              evValid;
  logic              evOn;
  logic [NW-1:0]     evNote;
  logic              evAck;
  logic [NV-1:0]     voiceGate;
  logic [NV*NW-1:0]  voiceNote;
  logic [NV-1:0]     voiceStart;
  logic              steal;
  logic [3:0]        activeCnt;

  voice_alloc #(
    .C_VOICES     (NV),
    .C_NOTE_WIDTH (NW),
    .C_AGE_WIDTH  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evValid    (evValid),
    .evOn       (evOn),
    .evNote     (evNote),
    .evAck      (evAck),
    .voiceGate  (voiceGate),
    .voiceNote  (voiceNote),
    .voiceStart (voiceStart),
    .steal      (steal),
    .activeCnt  (activeCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NV-1:0]    gate;
    logic [NV*NW-1:0] notes;
    logic [NV-1:0]    start;
    logic             stl;
    logic [3:0]       cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;

  // Reference voice model.
  logic          m_gate[NV];
  logic [NW-1:0] m_note[NV];
  int            m_age[NV];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = '0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_event(input logic on, input logic [NW-1:0] n, output exp_t e);
    int tgt;
    int best;
    bit stl;
    tgt = -1;
    stl = 1'b0;
    e   = '0;
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
    if (on) begin
      if (tgt < 0)
        for (int i = 0; i < NV; i++)
          if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        best = 0;
        for (int i = 1; i < NV; i++)
          if (m_age[i] > m_age[best]) best = i;
        tgt = best;
        stl = 1'b1;
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
      m_gate[tgt]  = 1'b1;
      m_note[tgt]  = n;
      m_age[tgt]   = 0;
      e.start[tgt] = 1'b1;
    end else if (tgt >= 0) begin
      m_gate[tgt] = 1'b0;
    end
    e.stl = stl;
    for (int i = 0; i < NV; i++) begin
      e.gate[i]             = m_gate[i];
      e.notes[i*NW +: NW]   = m_note[i];
      e.cnt                 = e.cnt + 4'(m_gate[i]);
    end
  endtask

  // One full handshake: predict, drive, time the ack, compare the result.
  task automatic send(input logic on, input logic [NW-1:0] n, input string tag);
    exp_t e;
    int   lat;
    model_event(on, n, e);
    sb_q.push_back(e);
    @(negedge clk);
    evValid = 1'b1;
    evOn    = on;
    evNote  = n;
    lat     = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      // Scramble the event fields: the DUT must use its latched copy.
      evOn   = ~on;
      evNote = ~n;
      if (evAck) begin
        lat = k;
        break;
      end
    end
    check({tag, " ack latency"}, 64'(lat), 64'd2);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, " gate"},  64'(voiceGate),  64'(e.gate));
    check({tag, " notes"}, 64'(voiceNote),  64'(e.notes));
    check({tag, " start"}, 64'(voiceStart), 64'(e.start));
    check({tag, " steal"}, 64'(steal),      64'(e.stl));
    check({tag, " cnt"},   64'(activeCnt),  64'(e.cnt));
    evValid = 1'b0;
    @(negedge clk);
    check({tag, " start cleared"}, 64'(voiceStart), 64'd0);
    check({tag, " steal cleared"}, 64'(steal),      64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst     = 1'b1;
    evValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check({tag, " gate"},  64'(voiceGate),  64'd0);
    check({tag, " notes"}, 64'(voiceNote),  64'd0);
    check({tag, " start"}, 64'(voiceStart), 64'd0);
    check({tag, " steal"}, 64'(steal),      64'd0);
    check({tag, " cnt"},   64'(activeCnt),  64'd0);
    check({tag, " ack"},   64'(evAck),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    int   acks;

    rst     = 1'b1;
    evValid = 1'b0;
    evOn    = 1'b0;
    evNote  = '0;
    model_reset();

    // Reset state, first note-on, then a repeated note-on.
    do_reset("reset");
    send(1'b1, 7'd60, "on60");
    check("on60 gate const",  64'(voiceGate),        64'b0001);
    check("on60 note0 const", 64'(voiceNote[6:0]),   64'd60);
    check("on60 cnt const",   64'(activeCnt),        64'd1);
    send(1'b1, 7'd60, "retrig60");
    check("retrig60 cnt const", 64'(activeCnt), 64'd1);

    // Fill all voices, then steal the oldest twice.
    do_reset("reset2");
    send(1'b1, 7'd60, "fill60");
    send(1'b1, 7'd62, "fill62");
    send(1'b1, 7'd64, "fill64");
    send(1'b1, 7'd65, "fill65");
    send(1'b1, 7'd67, "steal67");
    check("steal67 gate const",  64'(voiceGate),      64'b1111);
    check("steal67 note0 const", 64'(voiceNote[6:0]), 64'd67);
    send(1'b1, 7'd69, "steal69");
    check("steal69 note1 const", 64'(voiceNote[13:7]), 64'd69);

    // Age saturation: ties among saturated voices go to the lowest index.
    do_reset("reset3");
    send(1'b1, 7'd60, "sat60");
    send(1'b1, 7'd62, "sat62");
    send(1'b1, 7'd64, "sat64");
    send(1'b1, 7'd65, "sat65");
    send(1'b1, 7'd65, "sat65r1");
    send(1'b1, 7'd65, "sat65r2");
    send(1'b1, 7'd67, "sat67");
    check("sat67 note0 const", 64'(voiceNote[6:0]), 64'd67);

    // Note-off with and without a matching voice.
    do_reset("reset4");
    send(1'b1, 7'd60, "off_on60");
    send(1'b1, 7'd62, "off_on62");
    send(1'b0, 7'd60, "off60");
    check("off60 gate const",  64'(voiceGate),      64'b0010);
    check("off60 note0 const", 64'(voiceNote[6:0]), 64'd60);
    send(1'b0, 7'd70, "off70");

    // evValid held high for ten cycles yields exactly one acknowledge.
    model_event(1'b1, 7'd72, dummy);
    @(negedge clk);
    evValid = 1'b1;
    evOn    = 1'b1;
    evNote  = 7'd72;
    acks    = 0;
    repeat (10) begin
      @(negedge clk);
      if (evAck) acks++;
    end
    check("held ack count", 64'(acks), 64'd1);
    check("held gate",      64'(voiceGate), 64'b0011);
    evValid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset arriving during SCAN aborts the event.
    @(negedge clk);
    evValid = 1'b1;
    evOn    = 1'b1;
    evNote  = 7'd74;
    @(negedge clk);
    rst     = 1'b1;
    evValid = 1'b0;
    acks    = 0;
    repeat (4) begin
      @(negedge clk);
      if (evAck) acks++;
    end
    rst = 1'b0;
    model_reset();
    check("scan rst ack count", 64'(acks),       64'd0);
    check("scan rst gate",      64'(voiceGate),  64'd0);
    check("scan rst notes",     64'(voiceNote),  64'd0);
    check("scan rst start",     64'(voiceStart), 64'd0);
    check("scan rst steal",     64'(steal),      64'd0);
    check("scan rst cnt",       64'(activeCnt),  64'd0);

    // Allocation still works after the aborted event.
    send(1'b1, 7'd61, "post_rst61");

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
